data_mem_arbiter: RTL and testbench

Arbitrates the single load port and single store port of the 64-bit, 1024-word data memory BRAM among NUM_REQ requesters, such as GPU lanes/LSUs and the host/DMA loader. Each cycle it grants at most one load and at most one store, using independent round-robin pointers. It withholds a load that collides with a same-cycle store to the same word, and routes each load's data back to the issuing requester one cycle after the grant.

---
 rtl/data_mem_arbiter.sv | 95 +++++++++
 tb/tb_data_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Grants one load and one store per cycle to the data BRAM via round-robin; load data returns 1 cycle after the grant.
// A load colliding with the same-cycle store is withheld; responses cannot be back-pressured.
module data_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      mem_ld_en,
    output logic [ADDR_W-1:0]         mem_ld_addr,
    input  logic [DATA_W-1:0]         mem_ld_data,
    output logic                      mem_st_en,
    output logic [ADDR_W-1:0]         mem_st_addr,
    output logic [DATA_W-1:0]         mem_st_data
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ld_ptr, st_ptr;
    logic               tag_vld;
    logic [PTR_W-1:0]   tag_idx;
    logic [NUM_REQ-1:0] ld_cand, st_cand;
    logic               ld_hit, st_hit, ld_gnt, st_gnt;
    logic [PTR_W-1:0]   ld_sel, st_sel;
    logic [ADDR_W-1:0]  ld_addr_sel, st_addr_sel;
    logic [DATA_W-1:0]  st_data_sel;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        return PTR_W'((int'(base) + off) % NUM_REQ);
    endfunction

    assign ld_cand = req_valid & ~req_we;
    assign st_cand = req_valid & req_we;

    // Scan from the farthest offset down so the candidate nearest the pointer is written last and wins.
    always_comb begin
        ld_hit = 1'b0;
        ld_sel = '0;
        st_hit = 1'b0;
        st_sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (ld_cand[wrap_add(ld_ptr, k)]) begin
                ld_hit = 1'b1;
                ld_sel = wrap_add(ld_ptr, k);
            end
            if (st_cand[wrap_add(st_ptr, k)]) begin
                st_hit = 1'b1;
                st_sel = wrap_add(st_ptr, k);
            end
        end
    end

    assign ld_addr_sel = req_addr[int'(ld_sel)*ADDR_W +: ADDR_W];
    assign st_addr_sel = req_addr[int'(st_sel)*ADDR_W +: ADDR_W];
    assign st_data_sel = req_wdata[int'(st_sel)*DATA_W +: DATA_W];

    // Reset gates the grants so nothing reaches the BRAM or the requesters while it is held.
    assign st_gnt = st_hit && !rst;
    assign ld_gnt = ld_hit && !rst && !(st_gnt && (ld_addr_sel == st_addr_sel));

    assign req_ready = (st_gnt ? (NUM_REQ'(1) << st_sel) : '0)
                     | (ld_gnt ? (NUM_REQ'(1) << ld_sel) : '0);

    assign mem_ld_en   = ld_gnt;
    assign mem_ld_addr = ld_gnt ? ld_addr_sel : '0;
    assign mem_st_en   = st_gnt;
    assign mem_st_addr = st_gnt ? st_addr_sel : '0;
    assign mem_st_data = st_gnt ? st_data_sel : '0;

    assign rsp_valid = tag_vld ? (NUM_REQ'(1) << tag_idx) : '0;
    assign rsp_data  = tag_vld ? mem_ld_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_ptr  <= '0;
            st_ptr  <= '0;
            tag_vld <= 1'b0;
            tag_idx <= '0;
        end else begin
            if (st_gnt) st_ptr <= wrap_add(st_sel, 1);
            if (ld_gnt) begin
                ld_ptr  <= wrap_add(ld_sel, 1);
                tag_idx <= ld_sel;
            end
            tag_vld <= ld_gnt;
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter against a cycle-level reference model of the arbitration rules.
// Includes a BRAM model with one-cycle registered read.
module tb_data_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_data, mem_st_data;
    logic [DW-1:0]   mem_ld_data = '0;
    logic            mem_ld_en, mem_st_en;
    logic [AW-1:0]   mem_ld_addr, mem_st_addr;

    data_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_ld_en(mem_ld_en), .mem_ld_addr(mem_ld_addr), .mem_ld_data(mem_ld_data),
        .mem_st_en(mem_st_en), .mem_st_addr(mem_st_addr), .mem_st_data(mem_st_data)
    );

    function automatic logic [DW-1:0] pat(input int a);
        return {16'hC0DE, 6'b0, AW'(a), 22'h0, AW'(a)};
    endfunction

    logic          pre_en = 1'b1;
    logic [DW-1:0] bram [1024];
    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 1024; i++) bram[i] <= pat(i);
        end else begin
            if (mem_ld_en) mem_ld_data <= bram[mem_ld_addr];
            if (mem_st_en) bram[mem_st_addr] <= mem_st_data;
        end
    end

    // Pending request per requester, held until granted
    logic [N-1:0]  p_vld, p_we;
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_wd   [N];

    // Reference model state
    int            m_ld_ptr, m_st_ptr, m_tag_i;
    bit            m_tag_v;
    logic [DW-1:0] m_tag_d;
    logic [DW-1:0] ref_mem [1024];

    logic [N-1:0]  obs_ready, obs_rsp_v;
    logic [DW-1:0] obs_rsp_d;
    int            n_chk, n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_ld_ptr = 0;
        m_st_ptr = 0;
        m_tag_v  = 0;
        m_tag_i  = 0;
        m_tag_d  = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = p_vld[i];
            req_we[i]               = p_we[i];
            req_addr[i*AW +: AW]    = p_addr[i];
            req_wdata[i*DW +: DW]   = p_wd[i];
        end
    endtask

    // One clock cycle: apply pending requests, compare every output with the model, then advance the model.
    task automatic step();
        int            sg, lg;
        logic [N-1:0]  er, erv;
        logic [DW-1:0] erd, e_st_d;
        logic [AW-1:0] e_ld_a, e_st_a;
        drive();
        @(negedge clk);
        obs_ready = req_ready;
        obs_rsp_v = rsp_valid;
        obs_rsp_d = rsp_data;
        if (rst) model_reset();
        sg = -1;
        lg = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_st_ptr + k) % N;
                if (sg < 0 && p_vld[i] && p_we[i]) sg = i;
                i = (m_ld_ptr + k) % N;
                if (lg < 0 && p_vld[i] && !p_we[i]) lg = i;
            end
        end
        if (sg >= 0 && lg >= 0 && p_addr[lg] == p_addr[sg]) lg = -1;
        er = '0; e_ld_a = '0; e_st_a = '0; e_st_d = '0;
        if (sg >= 0) begin er[sg] = 1'b1; e_st_a = p_addr[sg]; e_st_d = p_wd[sg]; end
        if (lg >= 0) begin er[lg] = 1'b1; e_ld_a = p_addr[lg]; end
        erv = m_tag_v ? (N'(1) << m_tag_i) : '0;
        erd = m_tag_v ? m_tag_d : '0;
        chk("req_ready",   req_ready,   er);
        chk("mem_ld_en",   mem_ld_en,   lg >= 0);
        chk("mem_ld_addr", mem_ld_addr, e_ld_a);
        chk("mem_st_en",   mem_st_en,   sg >= 0);
        chk("mem_st_addr", mem_st_addr, e_st_a);
        chk("mem_st_data", mem_st_data, e_st_d);
        chk("rsp_valid",   rsp_valid,   erv);
        chk("rsp_data",    rsp_data,    erd);
        m_tag_v = 0;
        if (lg >= 0) begin
            m_tag_v  = 1;
            m_tag_i  = lg;
            m_tag_d  = ref_mem[p_addr[lg]];
            m_ld_ptr = (lg + 1) % N;
            p_vld[lg] = 1'b0;
        end
        if (sg >= 0) begin
            ref_mem[p_addr[sg]] = p_wd[sg];
            m_st_ptr  = (sg + 1) % N;
            p_vld[sg] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input int a, input logic [DW-1:0] d);
        p_vld[i]  = 1'b1;
        p_we[i]   = we;
        p_addr[i] = AW'(a);
        p_wd[i]   = d;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        p_vld = '0;
        p_we  = '0;
        for (int i = 0; i < N; i++) begin p_addr[i] = '0; p_wd[i] = '0; end
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        model_reset();
        drive();
        @(posedge clk);
        #1;
        pre_en = 1'b0;

        // Reset held with every requester asking for a load
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 100 + i, '0);
        repeat (3) begin
            step();
            chk("rst_ready", obs_ready, '0);
        end
        rst = 1'b0;

        // Load fairness: requester 0 first, then strict rotation
        for (int c = 0; c < 8; c++) begin
            step();
            chk("fair_ready", obs_ready, N'(1) << (c % N));
            if (c > 0) begin
                chk("fair_rsp_v", obs_rsp_v, N'(1) << ((c - 1) % N));
                chk("fair_rsp_d", obs_rsp_d, pat(100 + (c - 1) % N));
            end
            p_vld = '1;
        end
        p_vld = '0;

        // Store rotation starting from requester 0
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 200 + i, {32'h5700_0000, 32'(i)});
        for (int c = 0; c < N; c++) begin
            step();
            chk("st_fair_ready", obs_ready, N'(1) << c);
        end

        // Store then load of the same word on the next cycle
        set_req(2, 1'b1, 10'h3FF, 64'hDEAD_BEEF_0123_4567);
        step();
        set_req(1, 1'b0, 10'h3FF, '0);
        step();
        step();
        chk("sl_rsp_v", obs_rsp_v, 4'b0010);
        chk("sl_rsp_d", obs_rsp_d, 64'hDEAD_BEEF_0123_4567);

        // Same-cycle collision withholds the load for one cycle
        set_req(0, 1'b1, 5, 64'h0);
        step();
        set_req(0, 1'b1, 5, 64'h1);
        set_req(3, 1'b0, 5, '0);
        step();
        chk("col_ready0", obs_ready, 4'b0001);
        step();
        chk("col_ready1", obs_ready, 4'b1000);
        step();
        chk("col_rsp_v", obs_rsp_v, 4'b1000);
        chk("col_rsp_d", obs_rsp_d, 64'h1);
        set_req(0, 1'b1, 5, 64'h2);
        set_req(3, 1'b0, 6, '0);
        step();
        chk("nocol_ready", obs_ready, 4'b1001);
        step();
        chk("nocol_rsp_d", obs_rsp_d, pat(6));

        // Random traffic over a small address window to provoke collisions
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_vld[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), {$urandom, $urandom});
            end
            step();
        end
        p_vld = '0;
        repeat (2) step();

        // Reset arrives before the edge that would capture the load tag
        set_req(2, 1'b0, 9, '0);
        drive();
        @(negedge clk);
        chk("mid_gnt", req_ready, 4'b0100);
        chk("mid_ld_en", mem_ld_en, 1'b1);
        rst = 1'b1;
        p_vld = '0;
        model_reset();
        @(posedge clk);
        #1;
        step();
        chk("mid_rsp_v", obs_rsp_v, '0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 300 + i, '0);
        step();
        chk("mid_ld_ptr", obs_ready, 4'b0001);
        p_vld = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 310 + i, 64'(i));
        step();
        chk("mid_st_ptr", obs_ready, 4'b0001);
        chk("mid_rsp_after", obs_rsp_v, 4'b0001);
        p_vld = '0;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
